gate_pattern_checker: RTL and testbench
=======================================

# gate_pattern_checker

Self-checking stimulus driver and response reader for the 3-input AND-chain gate blocks (d = a&b, e = d&c) on the lab board. On a start pulse it walks all eight {a,b,c} combinations, holds each for a settle window, then samples the gate's d/e outputs and compares them against the expected values. It accumulates a mismatch count and a per-vector fail map, and raises done/pass for the LED/status logic. It sits between the board control logic and any gate under test.

## Interface
- SETTLE_CYCLES, default 4: cycles each vector is held before sampling; legal range 1..255.
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- d_i  input  1  gate-under-test output d.
- e_i  input  1  gate-under-test output e.
- a_o  output  1  stimulus a = idx[2].
- b_o  output  1  stimulus b = idx[1].
- c_o  output  1  stimulus c = idx[0].
- busy  output  1  high in SETTLE or SAMPLE.
- done  output  1  one-cycle pulse at sweep end.
- pass  output  1  high when the last sweep had zero mismatches; held until the next start.
- err_count  output  4  mismatching vectors in the last or current sweep, range 0..8.
- fail_vec  output  8  bit k set if vector k mismatched.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE. Vector index idx is 3 bits. Settle counter cnt is 8 bits.
- IDLE, start=1: idx<=0, cnt<=0, err_count<=0, fail_vec<=0, pass<=0, go to SETTLE.
- IDLE, start=0: hold all state.
- SETTLE: cnt increments each cycle. When cnt==SETTLE_CYCLES-1, cnt<=0 and go to SAMPLE.
- SAMPLE: expected d = idx[2]&idx[1]; expected e = idx[2]&idx[1]&idx[0].
  - If {d_i,e_i} differs from expected: err_count<=err_count+1 and fail_vec[idx]<=1.
  - If idx==7, go to DONE. Otherwise idx<=idx+1 and go to SETTLE.
- DONE: done=1 for this cycle. pass<=(err_count==0), using the final count including the last sample. Then go to IDLE.
- a_o/b_o/c_o are decoded directly from the idx register, so they are glitch-free. They hold the last vector (1,1,1) after the sweep until the next start.
- start outside IDLE is ignored. This includes start in the DONE cycle; the next sweep needs start in IDLE.
- A mismatch on both d and e for the same vector counts once.
- err_count saturates naturally at 8, since there are only eight vectors.

## Timing
- Reset values: state=IDLE, idx=0, cnt=0, a_o=b_o=c_o=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0.
- Let S = SETTLE_CYCLES and E0 = the edge that samples start=1.
- Vector 0 appears on a_o/b_o/c_o in the cycle after E0.
- Each vector is held S+1 cycles: S settle cycles plus 1 sample cycle.
- Vector k is compared at edge E0+(k+1)(S+1).
- done is high in the cycle after edge E0+8(S+1).
- pass and the final err_count/fail_vec are valid from the edge ending DONE. They are stable in IDLE.
- busy is high from the cycle after E0 through the last SAMPLE cycle. busy is low in DONE.
- Reset mid-sweep: all outputs return to reset values immediately and asynchronously. There is no done pulse. The next sweep needs a fresh start.
- The sampled d_i/e_i are the gate-under-test outputs, which are combinational from a_o/b_o/c_o. S≥1 guarantees at least one full cycle of settling.

## Structure
- Shared package gate_test_pkg contains:
  - the state enum (IDLE, SETTLE, SAMPLE, DONE);
  - constant NUM_VECTORS=8;
  - a function expected_de(idx) returning {d,e}.
- Sub-module gate_ref_model: combinational golden model, inputs a,b,c, outputs d,e. The checker instantiates it fed from idx. The bench reuses it as the known-good gate under test.
- The FSM, counters and scoreboard registers all live in gate_pattern_checker itself.

## Test plan
- Good gate, S=4: wire gate_ref_model as the gate under test and pulse start. Require done exactly at E0+40 cycles, pass=1, err_count=0, fail_vec=8'h00.
- d stuck-at-0: force d_i=0, e_i=0. Require err_count=2 (vectors 6,7), fail_vec=8'hC0, pass=0.
- e stuck-at-1: force e_i=1 with d correct. Require err_count=7, fail_vec=8'h7F, pass=0. Confirm the double-field mismatch on vector 7 cannot occur here, and that vector 6 counts once when d is also forced wrong.
- start held high throughout the sweep: require exactly one sweep and one done pulse. A second start in IDLE after done must clear err_count/fail_vec and rerun.
- rst_n low during vector 3 SETTLE: require all outputs at reset values immediately and no done pulse. A new start must run a full, clean sweep with pass=1.
- S=1: require a vector change every 2 cycles and done at E0+16. Compare the a_o/b_o/c_o sequence 0..7 against idx.

Source files
------------

// File: rtl/gate_test_pkg.sv
// Shared types and the golden {d,e} function for the AND-chain gate checker.
package gate_test_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam int NUM_VECTORS = 8;

    // idx = {a,b,c}; returns {d,e} with d = a&b, e = d&c
    function automatic logic [1:0] expected_de(input logic [2:0] idx);
        return {idx[2] & idx[1], idx[2] & idx[1] & idx[0]};
    endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model of the 3-input AND-chain gate block.
module gate_ref_model (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic d,
    output logic e
);

    assign d = a & b;
    assign e = d & c;

endmodule

// File: rtl/gate_pattern_checker.sv
// Walks all eight {a,b,c} vectors through a gate under test, lets each settle,
// then scores the gate's d/e against the golden model.
module gate_pattern_checker
    import gate_test_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       d_i,
    input  logic       e_i,
    output logic       a_o,
    output logic       b_o,
    output logic       c_o,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_vec
);

    localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [2:0] IDX_LAST = 3'(NUM_VECTORS - 1);

    state_t     state, state_nxt;
    logic [2:0] idx;
    logic [7:0] cnt;
    logic       exp_d, exp_e;
    logic       mismatch;
    logic       settle_end;
    logic       last_vec;

    gate_ref_model u_ref (
        .a (idx[2]),
        .b (idx[1]),
        .c (idx[0]),
        .d (exp_d),
        .e (exp_e)
    );

    // Either or both fields wrong counts as a single vector failure
    assign mismatch   = ({d_i, e_i} != {exp_d, exp_e});
    assign settle_end = (cnt == CNT_LAST);
    assign last_vec   = (idx == IDX_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETTLE;
            SETTLE:  if (settle_end) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = last_vec ? DONE : SETTLE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            cnt       <= '0;
            err_count <= '0;
            fail_vec  <= '0;
            pass      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx       <= '0;
                        cnt       <= '0;
                        err_count <= '0;
                        fail_vec  <= '0;
                        pass      <= 1'b0;
                    end
                end
                SETTLE: begin
                    cnt <= settle_end ? 8'd0 : cnt + 8'd1;
                end
                SAMPLE: begin
                    if (mismatch) begin
                        err_count     <= err_count + 4'd1;
                        fail_vec[idx] <= 1'b1;
                    end
                    if (!last_vec) idx <= idx + 3'd1;
                end
                DONE: begin
                    // err_count already includes the vector-7 sample here
                    pass <= (err_count == 4'd0);
                end
                default: ;
            endcase
        end
    end

    // Stimulus comes straight off the idx flops so the gate sees clean edges
    assign a_o  = idx[2];
    assign b_o  = idx[1];
    assign c_o  = idx[0];
    assign busy = (state == SETTLE) || (state == SAMPLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_gate_pattern_checker.sv
// Directed bench for gate_pattern_checker: good gate, stuck-at faults, held
// start, mid-sweep reset and the minimum settle window.
module tb_gate_pattern_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start0, start1;
    logic d_frc, d_val, e_frc, e_val;

    logic       a0, b0, c0, d0, e0, rd0, re0, busy0, done0, pass0;
    logic [3:0] err0;
    logic [7:0] fv0;
    logic       a1, b1, c1, rd1, re1, busy1, done1, pass1;
    logic [3:0] err1;
    logic [7:0] fv1;

    int checks = 0;
    int errors = 0;

    gate_ref_model gut0 (.a(a0), .b(b0), .c(c0), .d(rd0), .e(re0));
    assign d0 = d_frc ? d_val : rd0;
    assign e0 = e_frc ? e_val : re0;

    gate_pattern_checker #(.SETTLE_CYCLES(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .d_i(d0), .e_i(e0),
        .a_o(a0), .b_o(b0), .c_o(c0), .busy(busy0), .done(done0),
        .pass(pass0), .err_count(err0), .fail_vec(fv0)
    );

    gate_ref_model gut1 (.a(a1), .b(b1), .c(c1), .d(rd1), .e(re1));

    gate_pattern_checker #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .d_i(rd1), .e_i(re1),
        .a_o(a1), .b_o(b1), .c_o(c1), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(err1), .fail_vec(fv1)
    );

    // Pulse start0 for one edge (E0); return at the done cycle with n = edges after E0
    task automatic run_sweep0(output int n);
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        n = 0;
        while (!done0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!done0) begin
            checks++; errors++;
            $display("FAIL sweep_timeout: no done after %0d cycles", n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
        d_frc = 1'b0; d_val = 1'b0; e_frc = 1'b0; e_val = 1'b0;
        @(negedge clk);
        checks++;
        if ({a0, b0, c0, busy0, done0, pass0, err0, fv0} !== 18'd0) begin
            errors++;
            $display("FAIL reset_dut0: got %b want 0", {a0, b0, c0, busy0, done0, pass0, err0, fv0});
        end
        checks++;
        if ({a1, b1, c1, busy1, done1, pass1, err1, fv1} !== 18'd0) begin
            errors++;
            $display("FAIL reset_dut1: got %b want 0", {a1, b1, c1, busy1, done1, pass1, err1, fv1});
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy0, done0, err0, fv0, a0, b0, c0} !== 16'd0) begin
            errors++;
            $display("FAIL idle_hold: got %b want 0", {busy0, done0, err0, fv0, a0, b0, c0});
        end
    endtask

    task automatic test_good_gate();
        int n;
        d_frc = 1'b0; e_frc = 1'b0;
        run_sweep0(n);
        checks++;
        if (n !== 40) begin errors++; $display("FAIL good_done_time: got %0d want 40", n); end
        checks++;
        if (busy0 !== 1'b0) begin errors++; $display("FAIL good_busy_in_done: got %b want 0", busy0); end
        @(negedge clk);
        checks++;
        if (done0 !== 1'b0) begin errors++; $display("FAIL good_done_pulse_width: got %b want 0", done0); end
        checks++;
        if (pass0 !== 1'b1) begin errors++; $display("FAIL good_pass: got %b want 1", pass0); end
        checks++;
        if (err0 !== 4'd0) begin errors++; $display("FAIL good_err: got %0d want 0", err0); end
        checks++;
        if (fv0 !== 8'h00) begin errors++; $display("FAIL good_fail_vec: got %h want 00", fv0); end
        checks++;
        if ({a0, b0, c0} !== 3'b111) begin errors++; $display("FAIL good_hold_vec: got %b want 111", {a0, b0, c0}); end
    endtask

    task automatic test_d_stuck0();
        int n;
        d_frc = 1'b1; d_val = 1'b0; e_frc = 1'b1; e_val = 1'b0;
        run_sweep0(n);
        @(negedge clk);
        checks++;
        if (err0 !== 4'd2) begin errors++; $display("FAIL dstuck0_err: got %0d want 2", err0); end
        checks++;
        if (fv0 !== 8'hC0) begin errors++; $display("FAIL dstuck0_fail_vec: got %h want c0", fv0); end
        checks++;
        if (pass0 !== 1'b0) begin errors++; $display("FAIL dstuck0_pass: got %b want 0", pass0); end
    endtask

    task automatic test_e_stuck1();
        int n;
        d_frc = 1'b0; e_frc = 1'b1; e_val = 1'b1;
        run_sweep0(n);
        @(negedge clk);
        checks++;
        if (err0 !== 4'd7) begin errors++; $display("FAIL estuck1_err: got %0d want 7", err0); end
        checks++;
        if (fv0 !== 8'h7F) begin errors++; $display("FAIL estuck1_fail_vec: got %h want 7f", fv0); end
        checks++;
        if (pass0 !== 1'b0) begin errors++; $display("FAIL estuck1_pass: got %b want 0", pass0); end
        // d stuck 0 too: vector 6 now has both fields wrong, all eight fail
        d_frc = 1'b1; d_val = 1'b0;
        run_sweep0(n);
        @(negedge clk);
        checks++;
        if (err0 !== 4'd8) begin errors++; $display("FAIL both_err: got %0d want 8", err0); end
        checks++;
        if (fv0 !== 8'hFF) begin errors++; $display("FAIL both_fail_vec: got %h want ff", fv0); end
    endtask

    task automatic test_start_held();
        int dones = 0;
        int n;
        d_frc = 1'b1; d_val = 1'b0; e_frc = 1'b1; e_val = 1'b0;
        @(negedge clk) start0 = 1'b1;
        repeat (120) begin
            @(negedge clk);
            if (done0) begin dones++; start0 = 1'b0; end
        end
        start0 = 1'b0;
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL held_done_count: got %0d want 1", dones); end
        checks++;
        if (busy0 !== 1'b0) begin errors++; $display("FAIL held_idle: busy got %b want 0", busy0); end
        checks++;
        if ({err0, fv0} !== {4'd2, 8'hC0}) begin
            errors++; $display("FAIL held_result: got %0d/%h want 2/c0", err0, fv0);
        end
        d_frc = 1'b0; e_frc = 1'b0;
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        checks++;
        if ({busy0, err0, fv0} !== {1'b1, 4'd0, 8'h00}) begin
            errors++; $display("FAIL rerun_clear: got busy=%b err=%0d fv=%h want 1/0/00", busy0, err0, fv0);
        end
        n = 1;
        while (!done0 && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        checks++;
        if ({pass0, err0, fv0} !== {1'b1, 4'd0, 8'h00}) begin
            errors++; $display("FAIL rerun_result: got pass=%b err=%0d fv=%h want 1/0/00", pass0, err0, fv0);
        end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        int n;
        d_frc = 1'b0; e_frc = 1'b1; e_val = 1'b1;
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        repeat (16) @(negedge clk);
        checks++;
        if ({a0, b0, c0, busy0, err0, fv0} !== {3'b011, 1'b1, 4'd3, 8'h07}) begin
            errors++;
            $display("FAIL mid_pre_reset: got abc=%b busy=%b err=%0d fv=%h want 011/1/3/07",
                     {a0, b0, c0}, busy0, err0, fv0);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a0, b0, c0, busy0, done0, pass0, err0, fv0} !== 18'd0) begin
            errors++;
            $display("FAIL mid_async_reset: got %b want 0", {a0, b0, c0, busy0, done0, pass0, err0, fv0});
        end
        repeat (3) begin @(negedge clk); if (done0) dones++; end
        rst_n = 1'b1;
        repeat (50) begin @(negedge clk); if (done0 || busy0) dones++; end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL mid_no_done: got %0d activity cycles want 0", dones); end
        e_frc = 1'b0;
        run_sweep0(n);
        checks++;
        if (n !== 40) begin errors++; $display("FAIL mid_rerun_time: got %0d want 40", n); end
        @(negedge clk);
        checks++;
        if ({pass0, err0, fv0} !== {1'b1, 4'd0, 8'h00}) begin
            errors++; $display("FAIL mid_rerun_result: got pass=%b err=%0d fv=%h want 1/0/00", pass0, err0, fv0);
        end
    endtask

    task automatic test_settle1();
        logic [2:0] exp_v;
        int n;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        for (n = 0; n < 16; n++) begin
            exp_v = 3'(n / 2);
            checks++;
            if ({busy1, a1, b1, c1} !== {1'b1, exp_v}) begin
                errors++;
                $display("FAIL s1_vec_%0d: got busy=%b abc=%b want 1/%b", n, busy1, {a1, b1, c1}, exp_v);
            end
            @(negedge clk);
        end
        checks++;
        if ({done1, a1, b1, c1} !== 4'b1111) begin
            errors++; $display("FAIL s1_done_time: got done=%b abc=%b want 1/111", done1, {a1, b1, c1});
        end
        @(negedge clk);
        checks++;
        if ({pass1, err1, fv1} !== {1'b1, 4'd0, 8'h00}) begin
            errors++; $display("FAIL s1_result: got pass=%b err=%0d fv=%h want 1/0/00", pass1, err1, fv1);
        end
    endtask

    initial begin
        test_reset();
        test_good_gate();
        test_d_stuck0();
        test_e_stuck1();
        test_start_held();
        test_reset_mid();
        test_settle1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
